// File: rtl/ramrwp_arb4.sv
// rtl/ramrwp_arb4.sv - round-robin arbiter sharing one 1R1W RAM among NREQ requesters
module ramrwp_arb4 #(
  parameter int ADDRBIT = 11,
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int RDLAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    halt,
  input  logic [NREQ-1:0]         rdreq,
  input  logic [NREQ*ADDRBIT-1:0] ra,
  output logic [NREQ-1:0]         rdack,
  output logic [NREQ-1:0]         rdvld,
  output logic [WIDTH-1:0]        rdo,
  input  logic [NREQ-1:0]         wrreq,
  input  logic [NREQ*ADDRBIT-1:0] wa,
  input  logic [NREQ*WIDTH-1:0]   di,
  output logic [NREQ-1:0]         wrack,
  output logic                    ram_re,
  output logic [ADDRBIT-1:0]      ram_ra,
  input  logic [WIDTH-1:0]        ram_do,
  output logic                    ram_we,
  output logic [ADDRBIT-1:0]      ram_wa,
  output logic [WIDTH-1:0]        ram_di
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // First eligible requester at or after ptr, wrapping modulo NREQ
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] elig,
                                              input logic [PW-1:0]   ptr);
    logic [NREQ-1:0] g;
    logic            found;
    int              idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && elig[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [PW-1:0] oh_idx(input logic [NREQ-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = PW'(i);
    end
    return idx;
  endfunction

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] g);
    return PW'((int'(g) + 1) % NREQ);
  endfunction

  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [NREQ-1:0]        rd_elig;
  logic [NREQ-1:0]        wr_elig;
  logic [NREQ-1:0]        rd_gnt;
  logic [NREQ-1:0]        wr_gnt;
  logic [PW-1:0]          rd_gidx;
  logic [PW-1:0]          wr_gidx;
  logic [ADDRBIT-1:0]     rd_addr;
  logic [ADDRBIT-1:0]     wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic [RDLAT:0]         tag_vld;
  logic [RDLAT:0][PW-1:0] tag_idx;
  logic [NREQ-1:0]        ret_oh;

  // Grant selection: a requester acked this cycle sits out, halt blocks all grants
  always_comb begin
    rd_elig = halt ? '0 : (rdreq & ~rdack);
    wr_elig = halt ? '0 : (wrreq & ~wrack);
    rd_gnt  = rr_pick(rd_elig, rd_ptr);
    wr_gnt  = rr_pick(wr_elig, wr_ptr);
    rd_gidx = oh_idx(rd_gnt);
    wr_gidx = oh_idx(wr_gnt);
    rd_addr = ra[int'(rd_gidx)*ADDRBIT +: ADDRBIT];
    wr_addr = wa[int'(wr_gidx)*ADDRBIT +: ADDRBIT];
    wr_data = di[int'(wr_gidx)*WIDTH +: WIDTH];
  end

  // Read port issue: register grant, drive RAM read, advance read pointer
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rdack  <= '0;
      ram_re <= 1'b0;
      ram_ra <= '0;
      rd_ptr <= '0;
    end else begin
      rdack  <= rd_gnt;
      ram_re <= |rd_gnt;
      if (|rd_gnt) begin
        ram_ra <= rd_addr;
        rd_ptr <= ptr_after(rd_gidx);
      end
    end
  end

  // Write port issue: register grant, drive RAM write, advance write pointer
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wrack  <= '0;
      ram_we <= 1'b0;
      ram_wa <= '0;
      ram_di <= '0;
      wr_ptr <= '0;
    end else begin
      wrack  <= wr_gnt;
      ram_we <= |wr_gnt;
      if (|wr_gnt) begin
        ram_wa <= wr_addr;
        ram_di <= wr_data;
        wr_ptr <= ptr_after(wr_gidx);
      end
    end
  end

  // Tag pipe tracks which requester owns each in-flight read; keeps shifting under halt
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      tag_vld <= '0;
      tag_idx <= '0;
    end else begin
      tag_vld[0] <= |rd_gnt;
      tag_idx[0] <= rd_gidx;
      for (int k = 1; k <= RDLAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end
    end
  end

  // One-hot owner of the read data arriving from the RAM this cycle
  always_comb begin
    ret_oh                 = '0;
    ret_oh[tag_idx[RDLAT]] = tag_vld[RDLAT];
  end

  // Read return: register RAM data with its owner; rdo holds between returns
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rdvld <= '0;
      rdo   <= '0;
    end else begin
      rdvld <= ret_oh;
      if (tag_vld[RDLAT]) rdo <= ram_do;
    end
  end

endmodule

// File: tb/tb_ramrwp_arb4.sv
// tb/tb_ramrwp_arb4.sv - self-checking bench for ramrwp_arb4
module tb_ramrwp_arb4;
  localparam int ADDRBIT = 11;
  localparam int WIDTH   = 8;
  localparam int NREQ    = 4;
  localparam int RDLAT   = 2;
  localparam int DEPTH   = 1 << ADDRBIT;

  logic                    clk;
  logic                    rst_;
  logic                    halt;
  logic [NREQ-1:0]         rdreq;
  logic [NREQ*ADDRBIT-1:0] ra;
  logic [NREQ-1:0]         rdack;
  logic [NREQ-1:0]         rdvld;
  logic [WIDTH-1:0]        rdo;
  logic [NREQ-1:0]         wrreq;
  logic [NREQ*ADDRBIT-1:0] wa;
  logic [NREQ*WIDTH-1:0]   di;
  logic [NREQ-1:0]         wrack;
  logic                    ram_re;
  logic [ADDRBIT-1:0]      ram_ra;
  logic [WIDTH-1:0]        ram_do;
  logic                    ram_we;
  logic [ADDRBIT-1:0]      ram_wa;
  logic [WIDTH-1:0]        ram_di;

  ramrwp_arb4 #(.ADDRBIT(ADDRBIT), .WIDTH(WIDTH), .NREQ(NREQ), .RDLAT(RDLAT)) dut (
    .clk(clk), .rst_(rst_), .halt(halt),
    .rdreq(rdreq), .ra(ra), .rdack(rdack), .rdvld(rdvld), .rdo(rdo),
    .wrreq(wrreq), .wa(wa), .di(di), .wrack(wrack),
    .ram_re(ram_re), .ram_ra(ram_ra), .ram_do(ram_do),
    .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] init_val(input int a);
    if (a == 5) return 8'hA5;
    if (a == 3) return 8'h11;
    return WIDTH'(a) ^ 8'h5A;
  endfunction

  // RAM model: RDLAT-cycle read pipe, write visible to reads from the next cycle
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rp  [RDLAT];
  logic             mem_ready = 1'b0;
  assign ram_do = rp[RDLAT-1];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= init_val(a);
      mem_ready <= 1'b1;
    end else begin
      if (ram_re) rp[0] <= mem[ram_ra];
      for (int k = 1; k < RDLAT; k++) rp[k] <= rp[k-1];
      if (ram_we) mem[ram_wa] <= ram_di;
    end
  end

  typedef struct {
    logic [NREQ-1:0] rdreq;
    logic [NREQ-1:0] wrreq;
    logic            halt;
    logic [NREQ-1:0] exp_rd;
    logic [NREQ-1:0] exp_wr;
  } vec_t;

  typedef struct {
    int               g;
    logic [WIDTH-1:0] data;
    int               cyc;
  } sb_t;

  sb_t              sb[$];
  vec_t             vt[18];
  logic [WIDTH-1:0] shadow [DEPTH];
  logic [ADDRBIT-1:0] ra_v [NREQ];
  logic [ADDRBIT-1:0] wa_v [NREQ];
  logic [WIDTH-1:0]   di_v [NREQ];
  logic [WIDTH-1:0]   last_data;
  int total;
  int bad;
  int cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int oh2i(input logic [NREQ-1:0] oh);
    for (int i = 0; i < NREQ; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic pack();
    for (int i = 0; i < NREQ; i++) begin
      ra[i*ADDRBIT +: ADDRBIT] = ra_v[i];
      wa[i*ADDRBIT +: ADDRBIT] = wa_v[i];
      di[i*WIDTH +: WIDTH]     = di_v[i];
    end
  endtask

  // Advance one cycle and check the read-return bus against the scoreboard
  task automatic tick();
    logic [63:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = 64'd1 << sb[0].g;
      chk("rdvld", rdvld, e);
      chk("rdo", rdo, sb[0].data);
      last_data = sb[0].data;
      void'(sb.pop_front());
    end else begin
      chk("rdvld_idle", rdvld, 0);
    end
  endtask

  task automatic apply(input logic [NREQ-1:0] rq, input logic [NREQ-1:0] wq, input logic h,
                       input logic [NREQ-1:0] er, input logic [NREQ-1:0] ew);
    int g;
    rdreq = rq;
    wrreq = wq;
    halt  = h;
    pack();
    tick();
    chk("rdack", rdack, er);
    chk("wrack", wrack, ew);
    chk("ram_re", ram_re, |er);
    chk("ram_we", ram_we, |ew);
    if (er != 0) begin
      g = oh2i(er);
      chk("ram_ra", ram_ra, ra_v[g]);
      sb.push_back('{g: g, data: shadow[ra_v[g]], cyc: cyc + RDLAT + 1});
    end
    if (ew != 0) begin
      g = oh2i(ew);
      chk("ram_wa", ram_wa, wa_v[g]);
      chk("ram_di", ram_di, di_v[g]);
      shadow[wa_v[g]] = di_v[g];
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rdack"}, rdack, 0);
    chk({tag, "_rdvld"}, rdvld, 0);
    chk({tag, "_rdo"}, rdo, 0);
    chk({tag, "_wrack"}, wrack, 0);
    chk({tag, "_ram_re"}, ram_re, 0);
    chk({tag, "_ram_ra"}, ram_ra, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_wa"}, ram_wa, 0);
    chk({tag, "_ram_di"}, ram_di, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply('0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    last_data = '0;
    for (int a = 0; a < DEPTH; a++) shadow[a] = init_val(a);
    for (int i = 0; i < NREQ; i++) begin
      ra_v[i] = ADDRBIT'(16 + i);
      wa_v[i] = ADDRBIT'(32 + i);
      di_v[i] = WIDTH'(128 + i);
    end

    // rdreq, wrreq, halt, expected rdack, expected wrack
    for (int i = 0; i < 8; i++)
      vt[i] = '{4'b1111, 4'b0000, 1'b0, 4'(1 << (i % 4)), 4'b0000};
    for (int i = 0; i < 4; i++)
      vt[8+i] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 4'(1 << i)};
    vt[12] = '{4'b0101, 4'b0011, 1'b0, 4'b0001, 4'b0001};
    vt[13] = '{4'b0101, 4'b0011, 1'b0, 4'b0100, 4'b0010};
    vt[14] = '{4'b0101, 4'b0011, 1'b0, 4'b0001, 4'b0001};
    vt[15] = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000};
    vt[16] = '{4'b1111, 4'b0000, 1'b0, 4'b0010, 4'b0000};
    vt[17] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000};

    rst_  = 1'b0;
    halt  = 1'b0;
    rdreq = '0;
    wrreq = '0;
    pack();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_ = 1'b1;

    for (int i = 0; i < 18; i++)
      apply(vt[i].rdreq, vt[i].wrreq, vt[i].halt, vt[i].exp_rd, vt[i].exp_wr);
    idle(RDLAT + 2);

    // single read of RAM[5] by requester 1
    ra_v[1] = 11'h005;
    apply(4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000);
    idle(RDLAT + 2);

    // same-cycle read and write of address 3: old data, then new data
    wa_v[0] = 11'h003;
    di_v[0] = 8'h3C;
    ra_v[2] = 11'h003;
    apply(4'b0100, 4'b0001, 1'b0, 4'b0100, 4'b0001);
    idle(1);
    apply(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000);
    idle(RDLAT + 2);

    // pointer wrap: last grant 3, then 1001 grants 0 before 3
    ra_v[3] = 11'h7FF;
    apply(4'b1000, 4'b0000, 1'b0, 4'b1000, 4'b0000);
    idle(1);
    apply(4'b1001, 4'b0000, 1'b0, 4'b0001, 4'b0000);
    apply(4'b1001, 4'b0000, 1'b0, 4'b1000, 4'b0000);

    // halt: in-flight read still returns, no grants, then 0 and 1 in order
    for (int i = 0; i < 5; i++) apply(4'b0011, 4'b0011, 1'b1, 4'b0000, 4'b0000);
    apply(4'b0011, 4'b0000, 1'b0, 4'b0001, 4'b0000);
    apply(4'b0011, 4'b0000, 1'b0, 4'b0010, 4'b0000);
    idle(RDLAT + 2);

    // reset with reads in flight
    apply(4'b0110, 4'b0000, 1'b0, 4'b0100, 4'b0000);
    apply(4'b0110, 4'b0000, 1'b0, 4'b0010, 4'b0000);
    rst_ = 1'b0;
    #1;
    check_zero("midreset");
    sb.delete();
    tick();
    tick();
    rst_ = 1'b1;
    apply(4'b0110, 4'b0000, 1'b0, 4'b0010, 4'b0000);

    for (int i = 0; i < RDLAT + 6 && sb.size() > 0; i++) idle(1);
    chk("sb_empty", sb.size(), 0);
    idle(2);
    chk("rdo_hold", rdo, last_data);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
